// File: rtl/player_pkg.sv
// Shared types and default parameters for the player life/respawn sequencer.
package player_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIVE,
        HIT_BLINK,
        RESPAWN,
        DEAD
    } plyr_state_t;

    localparam int DEF_INIT_LIVES    = 3;
    localparam int DEF_BLINK_TICKS   = 8;
    localparam int DEF_RESPAWN_TICKS = 2;

    localparam logic [7:0] PLAYER_COLOR = 8'h5c;

endpackage

// File: rtl/rise_edge_det.sv
// Registered rising-edge detector; rise is high for the first cycle that in is high.
module rise_edge_det
    import player_pkg::*;
(
    input  logic clk,
    input  logic resetN,
    input  logic in,
    output logic rise
);

    logic in_d;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            in_d <= 1'b0;
        end else begin
            in_d <= in;
        end
    end

    assign rise = in & ~in_d;

endmodule

// File: rtl/player_life_ctrl.sv
// Player life/respawn sequencer: owns the lives count and drives visibility,
// movement and invulnerability gates through hit-blink-respawn cycles.
//
//   state     | meaning
//   IDLE      | menu, all gates closed, lives parked at INIT_LIVES
//   ALIVE     | normal play, player solid and vulnerable
//   HIT_BLINK | just hit, frozen, blinking on cnt[0], counting ticks
//   RESPAWN   | recentred, can move, still invulnerable for a few ticks
//   DEAD      | last life lost, gameOver held until playGame drops
module player_life_ctrl
    import player_pkg::*;
#(
    parameter int INIT_LIVES    = DEF_INIT_LIVES,
    parameter int LIVES_W       = 3,
    parameter int BLINK_TICKS   = DEF_BLINK_TICKS,
    parameter int RESPAWN_TICKS = DEF_RESPAWN_TICKS
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               playGame,
    input  logic               tick,
    input  logic               playerHit,
    input  logic               extraLife,
    output logic [LIVES_W-1:0] lives,
    output logic               playerVisible,
    output logic               moveEnable,
    output logic               invulnerable,
    output logic               respawnPulse,
    output logic               gameOver
);

    localparam int CNT_MAX = (BLINK_TICKS > RESPAWN_TICKS) ? BLINK_TICKS : RESPAWN_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]   BLINK_LOAD   = CNT_W'(BLINK_TICKS);
    localparam logic [CNT_W-1:0]   RESPAWN_LOAD = CNT_W'(RESPAWN_TICKS);
    localparam logic [LIVES_W-1:0] LIVES_INIT   = LIVES_W'(INIT_LIVES);
    localparam logic [LIVES_W-1:0] LIVES_MAX    = '1;
    localparam logic [LIVES_W-1:0] LIVES_ONE    = LIVES_W'(1);

    plyr_state_t        state;
    logic [CNT_W-1:0]   cnt;
    logic               tick_rise;
    logic [LIVES_W-1:0] lives_inc;
    logic [LIVES_W-1:0] hit_lives;

    rise_edge_det u_tick_edge (
        .clk    (clk),
        .resetN (resetN),
        .in     (tick),
        .rise   (tick_rise)
    );

    assign lives_inc = (lives == LIVES_MAX) ? lives : lives + LIVES_ONE;
    // ALIVE always holds lives >= 1, so a hit with a bonus nets out to no change.
    assign hit_lives = extraLife ? lives : lives - LIVES_ONE;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            lives        <= LIVES_INIT;
            cnt          <= '0;
            respawnPulse <= 1'b0;
        end else begin
            respawnPulse <= 1'b0;
            if (!playGame) begin
                state <= IDLE;
                lives <= LIVES_INIT;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ALIVE;
                        lives <= LIVES_INIT;
                        cnt   <= '0;
                    end
                    ALIVE: begin
                        if (playerHit) begin
                            if (hit_lives == '0) begin
                                state <= DEAD;
                                lives <= '0;
                            end else begin
                                state <= HIT_BLINK;
                                lives <= hit_lives;
                                cnt   <= BLINK_LOAD;
                            end
                        end else if (extraLife) begin
                            lives <= lives_inc;
                        end
                    end
                    HIT_BLINK: begin
                        if (extraLife) begin
                            lives <= lives_inc;
                        end
                        if (tick_rise) begin
                            if (cnt == CNT_ONE) begin
                                state        <= RESPAWN;
                                cnt          <= RESPAWN_LOAD;
                                respawnPulse <= 1'b1;
                            end else begin
                                cnt <= cnt - CNT_ONE;
                            end
                        end
                    end
                    RESPAWN: begin
                        if (extraLife) begin
                            lives <= lives_inc;
                        end
                        if (tick_rise) begin
                            if (cnt == CNT_ONE) begin
                                state <= ALIVE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt - CNT_ONE;
                            end
                        end
                    end
                    DEAD: begin
                        lives <= '0;
                        cnt   <= '0;
                    end
                    default: begin
                        state <= IDLE;
                        lives <= LIVES_INIT;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        playerVisible = 1'b0;
        moveEnable    = 1'b0;
        invulnerable  = 1'b0;
        gameOver      = 1'b0;
        case (state)
            ALIVE: begin
                playerVisible = 1'b1;
                moveEnable    = 1'b1;
            end
            HIT_BLINK: begin
                playerVisible = ~cnt[0];
                invulnerable  = 1'b1;
            end
            RESPAWN: begin
                playerVisible = 1'b1;
                moveEnable    = 1'b1;
                invulnerable  = 1'b1;
            end
            DEAD: begin
                invulnerable = 1'b1;
                gameOver     = 1'b1;
            end
            default: begin
                playerVisible = 1'b0;
            end
        endcase
    end

endmodule
